// File: rtl/conv_req_arbiter.sv
// conv_req_arbiter: round-robin front end that shares one gray/BCD/excess-3 converter among NREQ requesters.
// Optional WAIT-state timeout is compiled in when CONV_ARB_TIMEOUT_EN is defined.
module conv_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [4*NREQ-1:0]    req_data,
    input  logic [2*NREQ-1:0]    req_sel,
    output logic [NREQ-1:0]      req_ready,
    output logic                 conv_start,
    output logic [3:0]           conv_in,
    output logic [1:0]           conv_sel,
    input  logic                 conv_done,
    input  logic [7:0]           conv_result,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [7:0]           rsp_data,
    output logic                 rsp_err,
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_WAIT  = 2'b10,
        S_RESP  = 2'b11
    } state_e;

    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};
    localparam logic [1:0]      SEL_ILLEGAL = 2'b11;

    state_e          state_q, state_d;
    logic [IDW-1:0]  last_q, last_d;
    logic [3:0]      data_q, data_d;
    logic [1:0]      sel_q, sel_d;
    logic [IDW-1:0]  id_q, id_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [7:0]      rsp_data_q, rsp_data_d;
    logic            rsp_err_q, rsp_err_d;

    logic [NREQ-1:0] hi_pick_s;
    logic [NREQ-1:0] any_pick_s;
    logic [NREQ-1:0] grant_s;
    logic [IDW-1:0]  grant_id_s;
    logic [3:0]      grant_data_s;
    logic [1:0]      grant_sel_s;
    logic            ready_en_s;
    logic            accept_s;

`ifdef CONV_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout_s;
    assign unused_timeout_s = ^TIMEOUT;
`endif

    // Round-robin pick: lowest valid index above last, else lowest valid index overall (wrap).
    always_comb begin
        hi_pick_s  = '0;
        any_pick_s = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            any_pick_s = req_valid[i] ? (ONE_HOT0 << i) : any_pick_s;
            hi_pick_s  = (req_valid[i] && (i > int'(last_q))) ? (ONE_HOT0 << i) : hi_pick_s;
        end
        grant_s = (|hi_pick_s) ? hi_pick_s : any_pick_s;
    end

    // Encode the granted index and mux its code and select.
    always_comb begin
        grant_id_s   = '0;
        grant_data_s = 4'h0;
        grant_sel_s  = 2'b00;
        for (int i = 0; i < NREQ; i++) begin
            grant_id_s   = grant_s[i] ? IDW'(i) : grant_id_s;
            grant_data_s = grant_s[i] ? req_data[4*i +: 4] : grant_data_s;
            grant_sel_s  = grant_s[i] ? req_sel[2*i +: 2] : grant_sel_s;
        end
    end

    assign ready_en_s = (state_q == S_IDLE) && !rst;
    assign req_ready  = ready_en_s ? grant_s : '0;
    assign accept_s   = ready_en_s && (|grant_s);

    // Next-state and datapath-latch logic for the transaction sequencer.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        data_d      = data_q;
        sel_d       = sel_q;
        id_d        = id_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = 1'b0;
`ifdef CONV_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    data_d = grant_data_s;
                    sel_d  = grant_sel_s;
                    id_d   = grant_id_s;
                    if (grant_sel_s == SEL_ILLEGAL) begin
                        // Illegal select never reaches the converter; answer with an error right away.
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_id_d    = grant_id_s;
                        rsp_data_d  = 8'h00;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef CONV_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT: begin
                if (conv_done) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_data_d  = conv_result;
                    rsp_err_d   = 1'b0;
`ifdef CONV_ARB_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_data_d  = 8'h00;
                    rsp_err_d   = 1'b1;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
`else
                end else begin
                    state_d = S_WAIT;
                end
`endif
            end
            S_RESP: begin
                last_d  = rsp_id_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset; rr pointer starts at NREQ-1 so index 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            last_q      <= IDW'(NREQ - 1);
            data_q      <= 4'h0;
            sel_q       <= 2'b00;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= 8'h00;
            rsp_err_q   <= 1'b0;
`ifdef CONV_ARB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            data_q      <= data_d;
            sel_q       <= sel_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
`ifdef CONV_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign conv_start = (state_q == S_ISSUE);
    assign conv_in    = data_q;
    assign conv_sel   = sel_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_conv_req_arbiter.sv
// Self-checking bench for conv_req_arbiter: randomized requests against a transaction-level reference model.
// The timeout scenario follows CONV_ARB_TIMEOUT_EN the same way the design does.
module tb_conv_req_arbiter;

    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 15;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [4*NREQ-1:0]   req_data = '0;
    logic [2*NREQ-1:0]   req_sel = '0;
    logic [NREQ-1:0]     req_ready;
    logic                conv_start;
    logic [3:0]          conv_in;
    logic [1:0]          conv_sel;
    logic                conv_done = 1'b0;
    logic [7:0]          conv_result = 8'h00;
    logic                rsp_valid;
    logic [IDW-1:0]      rsp_id;
    logic [7:0]          rsp_data;
    logic                rsp_err;
    logic                busy;

    int n_chk  = 0;
    int n_fail = 0;
    int m_last = NREQ - 1;

    always #5 clk = ~clk;

    conv_req_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_sel(req_sel), .req_ready(req_ready),
        .conv_start(conv_start), .conv_in(conv_in), .conv_sel(conv_sel),
        .conv_done(conv_done), .conv_result(conv_result),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference arbitration: first valid index after the last one served, wrapping.
    function automatic int model_pick(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (last + k) % NREQ;
            if (((v >> idx) & 4'b0001) != 4'b0000) return idx;
        end
        return -1;
    endfunction

    // Converter stand-in: gray, BCD, excess-3.
    function automatic logic [7:0] conv_ref(input logic [3:0] c, input logic [1:0] s);
        case (s)
            2'b00:   return {4'h0, c ^ (c >> 1)};
            2'b01:   return (c >= 4'd10) ? {4'h1, c - 4'd10} : {4'h0, c};
            2'b10:   return 8'(c) + 8'd3;
            default: return 8'h00;
        endcase
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_start"}, 32'(conv_start), 32'd0);
        chk({tag, "_in"},    32'(conv_in), 32'd0);
        chk({tag, "_sel"},   32'(conv_sel), 32'd0);
        chk({tag, "_rv"},    32'(rsp_valid), 32'd0);
        chk({tag, "_rid"},   32'(rsp_id), 32'd0);
        chk({tag, "_rdata"}, 32'(rsp_data), 32'd0);
        chk({tag, "_rerr"},  32'(rsp_err), 32'd0);
        chk({tag, "_ready"}, 32'(req_ready), 32'd0);
    endtask

    task automatic do_reset();
        req_valid   = '0;
        conv_done   = 1'b0;
        conv_result = 8'h00;
        rst         = 1'b1;
        @(posedge clk); #1;
        rst    = 1'b0;
        m_last = NREQ - 1;
        check_zero("rst");
    endtask

    task automatic idle_cycles(input int n);
        req_valid = '0;
        for (int c = 0; c < n; c++) begin
            #1;
            chk("idle_ready", 32'(req_ready), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    // One full transaction, entered and left in an IDLE cycle (#1 after the edge).
    task automatic run_txn(input logic [NREQ-1:0] vmask, input logic [4*NREQ-1:0] datav,
                           input logic [2*NREQ-1:0] selv, input int waitn);
        int         win;
        logic [3:0] code;
        logic [1:0] s;
        logic [7:0] res;
        logic [7:0] held;
        req_valid = vmask;
        req_data  = datav;
        req_sel   = selv;
        conv_done = 1'b0;
        #1;
        win  = model_pick(vmask, m_last);
        code = 4'(datav >> (4 * win));
        s    = 2'(selv >> (2 * win));
        res  = conv_ref(code, s);
        chk("grant", 32'(req_ready), 32'd1 << win);
        chk("accept_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        if (s == 2'b11) begin
            held = 8'h00;
            chk("ill_start", 32'(conv_start), 32'd0);
            chk("ill_rv", 32'(rsp_valid), 32'd1);
            chk("ill_rid", 32'(rsp_id), 32'(win));
            chk("ill_rerr", 32'(rsp_err), 32'd1);
            chk("ill_rdata", 32'(rsp_data), 32'd0);
        end else begin
            held = res;
            chk("start", 32'(conv_start), 32'd1);
            chk("conv_in", 32'(conv_in), 32'(code));
            chk("conv_sel", 32'(conv_sel), 32'(s));
            chk("issue_ready", 32'(req_ready), 32'd0);
            chk("issue_rv", 32'(rsp_valid), 32'd0);
            conv_done   = 1'($urandom_range(0, 1));
            conv_result = 8'($urandom);
            for (int w = 0; w <= waitn; w++) begin
                @(posedge clk); #1;
                chk("wait_start", 32'(conv_start), 32'd0);
                chk("wait_rv", 32'(rsp_valid), 32'd0);
                chk("wait_in", 32'(conv_in), 32'(code));
                chk("wait_ready", 32'(req_ready), 32'd0);
                conv_done   = (w == waitn);
                conv_result = (w == waitn) ? res : 8'($urandom);
            end
            @(posedge clk); #1;
            conv_done = 1'b0;
            chk("rsp_rv", 32'(rsp_valid), 32'd1);
            chk("rsp_rid", 32'(rsp_id), 32'(win));
            chk("rsp_rdata", 32'(rsp_data), 32'(res));
            chk("rsp_rerr", 32'(rsp_err), 32'd0);
            chk("rsp_ready", 32'(req_ready), 32'd0);
        end
        m_last = win;
        @(posedge clk); #1;
        chk("post_rv", 32'(rsp_valid), 32'd0);
        chk("post_rerr", 32'(rsp_err), 32'd0);
        chk("post_rid_hold", 32'(rsp_id), 32'(win));
        chk("post_rdata_hold", 32'(rsp_data), 32'(held));
        chk("post_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int   seen;
        int   lost;
        logic [2*NREQ-1:0] sv;

        do_reset();

        // Single requester, gray code of 5, done two WAIT cycles in.
        run_txn(4'b0001, 16'h0005, 8'h00, 2);

        // All requesters held valid from reset: order 0,1,2,3,0.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            run_txn(4'b1111, 16'($urandom), 8'h00, k % 3);
        end

        // Illegal select from requester 2.
        run_txn(4'b0100, 16'h0300, 8'b0011_0000, 0);

        // Reset while WAIT, then a stale done must be ignored.
        do_reset();
        req_valid = 4'b0010; req_data = 16'h00A0; req_sel = 8'b0000_0100;
        #1;
        chk("abort_grant", 32'(req_ready), 32'd2);
        @(posedge clk); #1;
        req_valid = '0;
        chk("abort_start", 32'(conv_start), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst    = 1'b0;
        m_last = NREQ - 1;
        check_zero("abort");
        conv_done = 1'b1; conv_result = 8'hAA;
        @(posedge clk); #1;
        conv_done = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("abort_norsp", 32'(rsp_valid), 32'd0);
            chk("abort_idle", 32'(busy), 32'd0);
            @(posedge clk); #1;
        end
        run_txn(4'b1111, 16'h4321, 8'b1001_0010, 1);

        // Done on the first WAIT cycle, immediately followed by another request.
        run_txn(4'b0110, 16'h0790, 8'b0001_1000, 0);
        run_txn(4'b0110, 16'h0C30, 8'b0010_0100, 0);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            sv = 8'($urandom);
            run_txn(4'($urandom_range(1, 15)), 16'($urandom), sv, $urandom_range(0, 4));
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 2));
        end

        // Done pulsed only during ISSUE.
        do_reset();
        req_valid = 4'b0001; req_data = 16'h0009; req_sel = 8'h01;
        #1;
        chk("to_grant", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = '0;
        chk("to_start", 32'(conv_start), 32'd1);
        conv_done = 1'b1; conv_result = 8'h09;
        @(posedge clk); #1;
        conv_done = 1'b0;
        seen = 0;
        lost = 0;
`ifdef CONV_ARB_TIMEOUT_EN
        for (int w = 0; w < TIMEOUT; w++) begin
            if (rsp_valid) seen = 1;
            @(posedge clk); #1;
        end
        chk("to_early_rsp", 32'(seen), 32'd0);
        chk("to_rv", 32'(rsp_valid), 32'd1);
        chk("to_rerr", 32'(rsp_err), 32'd1);
        chk("to_rdata", 32'(rsp_data), 32'd0);
        chk("to_rid", 32'(rsp_id), 32'd0);
        @(posedge clk); #1;
        chk("to_idle", 32'(busy), 32'd0);
`else
        for (int w = 0; w < 100; w++) begin
            if (rsp_valid) seen = 1;
            if (!busy) lost = 1;
            @(posedge clk); #1;
        end
        chk("hang_rsp", 32'(seen), 32'd0);
        chk("hang_busy_drop", 32'(lost), 32'd0);
        do_reset();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
